// File: rtl/sqrt_if.sv
// sqrt_if: operand and result valid/ready channels for sqrt_iter, with tag sideband.
interface sqrt_if #(
  parameter int IN_W   = 11,
  parameter int IN_FB  = 3,
  parameter int OUT_FB = 8,
  parameter int TAG_W  = 4
);
  localparam int OUT_W = (IN_W + 2 * OUT_FB - IN_FB + 1) / 2;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  a;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] q;
  logic [OUT_W:0]   rem;
  logic             exact;
  logic [TAG_W-1:0] out_tag;
  modport master (
    output in_valid, a, in_tag, out_ready,
    input  in_ready, out_valid, q, rem, exact, out_tag
  );
  modport slave (
    input  in_valid, a, in_tag, out_ready,
    output in_ready, out_valid, q, rem, exact, out_tag
  );
endinterface

// File: rtl/sqrt_iter.sv
// sqrt_iter: restoring digit-by-digit fixed-point floor(sqrt(a)), one root bit per cycle.
// Defining SQRT_ROUND_EN adds a one-cycle round-to-nearest step on q.
module sqrt_iter #(
  parameter int IN_W   = 11,
  parameter int IN_FB  = 3,
  parameter int OUT_FB = 8,
  parameter int TAG_W  = 4
) (
  input  logic clk,
  input  logic rst,
  sqrt_if.slave bus
);
  localparam int SH    = 2 * OUT_FB - IN_FB;
  localparam int RW    = (IN_W + SH + 1) / 2 * 2;
  localparam int OUT_W = RW / 2;
  localparam int CW    = $clog2(OUT_W + 1);
  typedef enum logic [1:0] {IDLE, CALC, ROUND, HOLD} state_t;
  state_t           state_q, state_d;
  logic [RW-1:0]    r_q, r_d;
  logic [OUT_W-1:0] root_q, root_d;
  logic [OUT_W:0]   rem_q, rem_d;
  logic [CW-1:0]    i_q, i_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [OUT_W+2:0] acc, trial;
  logic             fit, accept;
  assign bus.in_ready  = !rst && (state_q == IDLE || (state_q == HOLD && bus.out_ready));
  assign bus.out_valid = state_q == HOLD;
  assign bus.q         = root_q;
  assign bus.rem       = rem_q;
  assign bus.exact     = state_q == HOLD && rem_q == '0;
  assign bus.out_tag   = tag_q;
  assign accept        = bus.in_valid && bus.in_ready;
  // The radicand is consumed two bits at a time from its top, so it shifts left each step.
  assign acc   = {rem_q, r_q[RW-1 -: 2]};
  assign trial = {1'b0, root_q, 2'b01};
  assign fit   = acc >= trial;
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    root_d  = root_q;
    rem_d   = rem_q;
    i_d     = i_q;
    tag_d   = tag_q;
    case (state_q)
      CALC: begin
        rem_d  = fit ? (OUT_W+1)'(acc - trial) : (OUT_W+1)'(acc);
        root_d = {root_q[OUT_W-2:0], fit};
        r_d    = r_q << 2;
        i_d    = i_q - CW'(1);
        if (i_q == '0) begin
`ifdef SQRT_ROUND_EN
          state_d = ROUND;
`else
          state_d = HOLD;
`endif
        end
      end
      ROUND: begin
        root_d  = (rem_q > {1'b0, root_q} && root_q != '1) ? root_q + OUT_W'(1) : root_q;
        state_d = HOLD;
      end
      HOLD: state_d = bus.out_ready ? IDLE : HOLD;
      default: state_d = state_q;
    endcase
    if (accept) begin
      r_d     = RW'(bus.a) << SH;
      tag_d   = bus.in_tag;
      root_d  = '0;
      rem_d   = '0;
      i_d     = CW'(OUT_W - 1);
      state_d = (bus.a == '0) ? HOLD : CALC;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      root_q  <= '0;
      rem_q   <= '0;
      i_q     <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
      i_q     <= i_d;
      tag_q   <= tag_d;
    end
  end
endmodule

// File: tb/tb_sqrt_iter.sv
// tb_sqrt_iter: directed checks of sqrt_iter results, latency, backpressure and reset abort.
module tb_sqrt_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
`ifdef SQRT_ROUND_EN
  localparam int LAT = 13;
  localparam bit RND = 1'b1;
`else
  localparam int LAT = 12;
  localparam bit RND = 1'b0;
`endif
  sqrt_if bus ();
  sqrt_iter dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask
  task automatic run_op(input string nm, input logic [10:0] av, input logic [3:0] tv,
                        input int eq, input int er, input int ee, input int el);
    int n;
    bus.a        = av;
    bus.in_tag   = tv;
    bus.in_valid = 1'b1;
    chk({nm, "_in_ready"}, bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    wait_valid(n);
    chk({nm, "_lat"}, n, el);
    chk({nm, "_q"}, bus.q, eq);
    chk({nm, "_rem"}, bus.rem, er);
    chk({nm, "_exact"}, bus.exact, ee);
    chk({nm, "_tag"}, bus.out_tag, tv);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({nm, "_retired"}, bus.out_valid, 0);
  endtask
  initial begin
    int n;
    bit ok;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_q", bus.q, 0);
    chk("rst_rem", bus.rem, 0);
    chk("rst_exact", bus.exact, 0);
    chk("rst_tag", bus.out_tag, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);
    run_op("a32", 11'd32, 4'd1, 512, 0, 1, LAT);
    run_op("a16", 11'd16, 4'd2, 362, 28, 0, LAT);
    run_op("a1", 11'd1, 4'd5, RND ? 91 : 90, 92, 0, LAT);
    run_op("a2047", 11'd2047, 4'd9, RND ? 4095 : 4094, 8188, 0, LAT);
    run_op("a0", 11'd0, 4'd12, 0, 0, 1, 0);
    // Backpressure: result tag 3 held while tag 7 waits on the input.
    bus.a        = 11'd32;
    bus.in_tag   = 4'd3;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.a      = 11'd16;
    bus.in_tag = 4'd7;
    wait_valid(n);
    chk("bp_first_lat", n, LAT);
    ok = 1'b1;
    repeat (20) begin
      ok &= bus.out_valid === 1'b1 && bus.in_ready === 1'b0 && bus.q === 12'd512
            && bus.out_tag === 4'd3 && bus.rem === 13'd0;
      @(posedge clk);
      #1;
    end
    chk("bp_stable", ok, 1);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_same_edge_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("bp_calc_no_valid", bus.out_valid, 0);
    chk("bp_calc_in_ready", bus.in_ready, 0);
    wait_valid(n);
    chk("bp_second_lat", n, LAT);
    chk("bp_second_q", bus.q, 362);
    chk("bp_second_rem", bus.rem, 28);
    chk("bp_second_tag", bus.out_tag, 7);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    // Reset abort in the middle of CALC.
    bus.a        = 11'd32;
    bus.in_tag   = 4'd4;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_q", bus.q, 0);
    chk("mid_rst_tag", bus.out_tag, 0);
    rst = 1'b0;
    ok = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      ok &= bus.out_valid === 1'b0;
    end
    chk("abort_no_valid", ok, 1);
    run_op("after_rst_a32", 11'd32, 4'd6, 512, 0, 1, LAT);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
